// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the "100" detector run controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int FLUSH_CYC = 1;

endpackage

// File: rtl/seq100_jk.sv
// Moore serial "100" detector: y is high for the cycle after the final 0 is sampled.
module seq100_jk (
  input  logic clk,
  input  logic rst_n,
  input  logic i_x,
  output logic o_y
);

  typedef enum logic [1:0] {D_NONE, D_1, D_10, D_100} det_t;

  det_t r_state, w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= D_NONE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = D_NONE;
    case (r_state)
      D_NONE:  w_next = i_x ? D_1 : D_NONE;
      D_1:     w_next = i_x ? D_1 : D_10;
      D_10:    w_next = i_x ? D_1 : D_100;
      D_100:   w_next = i_x ? D_1 : D_NONE;
      default: w_next = D_NONE;
    endcase
  end

  assign o_y = (r_state == D_100);

endmodule

// File: rtl/seq_piso.sv
// Parallel-load, LSB-first shift register feeding the serial pattern.
module seq_piso #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_lsb
);

  logic [DATA_W-1:0] r_shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_shreg <= '0;
    else if (i_load)  r_shreg <= i_data;
    else if (i_shift) r_shreg <= r_shreg >> 1;
  end

  assign o_lsb = r_shreg[0];

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: serializes a pattern into a "100" detector and counts its hits
// over the len-sample window that trails the serial stream by one cycle.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int LEN_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_x_out,
  input  logic              i_y_in,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_hit_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state, w_next;
  logic [LEN_W-1:0]   r_rem;
  logic               r_x;
  logic               r_samp;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   w_len_c;
  logic               w_accept, w_load, w_shift, w_samp_en, w_lsb;

  assign w_len_c = (i_len > LEN_MAX) ? LEN_MAX : i_len;

  seq_piso #(.DATA_W(DATA_W)) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (i_data_in >> 1),
    .o_lsb   (w_lsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_load   = (w_len_c != '0);
          w_next   = (w_len_c != '0) ? S_SHIFT : S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_rem != '0) w_shift = 1'b1;
        else             w_next  = S_FLUSH;
      end
      S_FLUSH: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // y lags x by one cycle, so the first SHIFT cycle is skipped and FLUSH is sampled
  assign w_samp_en = ((r_state == S_SHIFT) && r_samp) || (r_state == S_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= 1'b0;
      r_rem  <= '0;
      r_samp <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_samp <= (r_state == S_SHIFT);
      if (w_load)       r_x <= i_data_in[0];
      else if (w_shift) r_x <= w_lsb;
      else              r_x <= 1'b0;
      if (w_load)       r_rem <= w_len_c - 1'b1;
      else if (w_shift) r_rem <= r_rem - 1'b1;
      if (w_accept)
        r_cnt <= '0;
      else if (w_samp_en && i_y_in && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_x_out   = r_x;
  assign o_busy    = (r_state == S_SHIFT) || (r_state == S_FLUSH);
  assign o_done    = (r_state == S_DONE);
  assign o_hit_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench: two controller+detector pairs (CNT_W=4 and CNT_W=1) on shared stimulus.
module tb_seq_detect_ctrl;
  import seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [5:0] data_in = '0;
  logic [2:0] len = '0;
  logic       x_a, y_a, busy_a, done_a;
  logic       x_b, y_b, busy_b, done_b;
  logic [3:0] hit_a;
  logic [0:0] hit_b;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #25 clk = ~clk;

  seq_detect_ctrl #(.DATA_W(6), .LEN_W(3), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_data_in(data_in), .i_len(len),
    .o_x_out(x_a), .i_y_in(y_a), .o_busy(busy_a), .o_done(done_a), .o_hit_cnt(hit_a)
  );
  seq100_jk u_det_a (.clk(clk), .rst_n(rst_n), .i_x(x_a), .o_y(y_a));

  seq_detect_ctrl #(.DATA_W(6), .LEN_W(3), .CNT_W(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_data_in(data_in), .i_len(len),
    .o_x_out(x_b), .i_y_in(y_b), .o_busy(busy_b), .o_done(done_b), .o_hit_cnt(hit_b)
  );
  seq100_jk u_det_b (.clk(clk), .rst_n(rst_n), .i_x(x_b), .o_y(y_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs at a negedge, accept on the next posedge, return at the following negedge.
  task automatic kick(input logic [5:0] d, input logic [2:0] l, input logic hold);
    @(negedge clk);
    data_in = d;
    len     = l;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Count cycles from the accept until done, noting whether busy was ever seen.
  task automatic wait_done(output int lat, output logic saw_busy);
    lat      = 0;
    saw_busy = 1'b0;
    while (!done_a && lat < 20) begin
      saw_busy |= busy_a;
      lat++;
      @(negedge clk);
    end
    if (!done_a) chk("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic run(input string tag, input logic [5:0] d, input logic [2:0] l,
                     input int eff_len, input int hits);
    int   lat;
    logic sb;
    kick(d, l, 1'b0);
    wait_done(lat, sb);
    chk({tag, "_lat"}, 32'(lat), (eff_len == 0) ? 32'd0 : 32'(eff_len + FLUSH_CYC));
    chk({tag, "_busy_seen"}, 32'(sb), (eff_len == 0) ? 32'd0 : 32'd1);
    chk({tag, "_busy_in_done"}, 32'(busy_a), 32'd0);
    chk({tag, "_hit"}, 32'(hit_a), 32'(hits));
    chk({tag, "_hit_sat"}, 32'(hit_b), (hits > 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_a), 32'd0);
    chk({tag, "_hit_hold"}, 32'(hit_a), 32'(hits));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [5:0] xs;
    int         lat;
    logic       sb;

    // async reset with no clock edge involved
    #5 rst_n = 1'b0;
    #5;
    chk("rst_x", 32'(x_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_hit", 32'(hit_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // serial stream and handshake timing for 001001
    xs = 6'b001001;
    kick(xs, 3'd6, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ser_x%0d", k), 32'(x_a), 32'(xs[k]));
      chk($sformatf("ser_busy%0d", k), 32'(busy_a), 32'd1);
      @(negedge clk);
    end
    chk("flush_busy", 32'(busy_a), 32'd1);
    chk("flush_x", 32'(x_a), 32'd0);
    chk("flush_done", 32'(done_a), 32'd0);
    @(negedge clk);
    chk("t2_done", 32'(done_a), 32'd1);
    chk("t2_busy", 32'(busy_a), 32'd0);
    chk("t2_hit", 32'(hit_a), 32'd2);
    chk("t2_hit_sat", 32'(hit_b), 32'd1);
    @(negedge clk);
    chk("t2_done_pulse", 32'(done_a), 32'd0);
    repeat (4) @(negedge clk);

    run("p100100", 6'b100100, 3'd6, 6, 1);
    run("p111111", 6'b111111, 3'd6, 6, 0);
    run("p001001", 6'b001001, 3'd6, 6, 2);
    run("len0",    6'b001001, 3'd0, 0, 0);
    run("len7",    6'b001001, 3'd7, 6, 2);
    run("len4",    6'b001001, 3'd4, 4, 1);

    // start held high: ignored while busy, re-accepted in the DONE cycle
    kick(6'b001001, 3'd6, 1'b1);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("hold_busy%0d", k), 32'(busy_a), 32'd1);
      chk($sformatf("hold_nodone%0d", k), 32'(done_a), 32'd0);
      @(negedge clk);
    end
    chk("hold_done", 32'(done_a), 32'd1);
    chk("hold_hit1", 32'(hit_a), 32'd2);
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 32'(busy_a), 32'd1);
    chk("restart_done", 32'(done_a), 32'd0);
    chk("restart_clr", 32'(hit_a), 32'd0);
    @(negedge clk);
    wait_done(lat, sb);
    chk("restart_lat", 32'(lat), 32'd6);
    chk("restart_hit", 32'(hit_a), 32'd2);
    repeat (4) @(negedge clk);

    // reset in the 3rd SHIFT cycle (x_out=1 there for 000101)
    kick(6'b000101, 3'd6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_x_before", 32'(x_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_hit", 32'(hit_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(busy_a), 32'd0);
    run("post_rst", 6'b001001, 3'd6, 6, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
